// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ==========================================================================
// fifo_wr_arbiter : round-robin, burst-limited arbiter onto one FIFO write port
// Rev 1.0
// ==========================================================================
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      req_data,
  output logic [N_REQ-1:0]         gnt,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [DW-1:0]            fifo_wr_data,
  output logic [$clog2(N_REQ)-1:0] fifo_src,
  output logic [15:0]              xfer_cnt
);

  localparam int SW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] C_LAST_IDX  = SW'(N_REQ - 1);
  localparam logic [BW-1:0] C_LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]   xfer_cnt_q, xfer_cnt_d;

  logic [DW-1:0] w_slot [N_REQ];
  logic [SW-1:0] w_pick_lo, w_pick_hi, w_pick, w_owner_nxt;
  logic          w_lo_vld, w_hi_vld, w_grant_ok, w_xfer;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign w_slot[g] = req_data[g*DW +: DW];
  end

  // Lowest requester at or above rr_ptr wins; otherwise wrap to lowest overall.
  always_comb begin
    w_pick_lo = '0;
    w_pick_hi = '0;
    w_lo_vld  = 1'b0;
    w_hi_vld  = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[SW'(j)]) begin
        w_pick_lo = SW'(j);
        w_lo_vld  = 1'b1;
        if (SW'(j) >= rr_ptr_q) begin
          w_pick_hi = SW'(j);
          w_hi_vld  = 1'b1;
        end
      end
    end
  end

  assign w_pick      = w_hi_vld ? w_pick_hi : w_pick_lo;
  assign w_owner_nxt = (owner_q == C_LAST_IDX) ? '0 : owner_q + SW'(1);
  assign w_grant_ok  = (state_q == BURST) && !fifo_full && !rst;
  assign w_xfer      = w_grant_ok && req[owner_q];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    xfer_cnt_d = xfer_cnt_q;
    gnt        = '0;
    if (w_grant_ok) gnt[owner_q] = 1'b1;
    case (state_q)
      IDLE: begin
        if (w_lo_vld) begin
          owner_d    = w_pick;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (w_xfer) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
        // A dropped request ends the tenure even while the FIFO is full.
        if (!req[owner_q] || (w_xfer && (beat_cnt_q == C_LAST_BEAT))) begin
          state_d  = IDLE;
          rr_ptr_d = w_owner_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign fifo_wr_en   = w_xfer;
  assign fifo_wr_data = w_slot[owner_q];
  assign fifo_src     = owner_q;
  assign xfer_cnt     = xfer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_fifo_wr_arbiter : directed-vector bench for fifo_wr_arbiter
// Rev 1.0
// ==========================================================================
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic [1:0]  fifo_src;
  logic [15:0] xfer_cnt;

  logic        rst_w;
  logic [1:0]  req_w;
  logic [15:0] req_data_w;
  logic [1:0]  gnt_w;
  logic        full_w;
  logic        wr_en_w;
  logic [7:0]  wr_data_w;
  logic [0:0]  src_w;
  logic [15:0] xfer_w;

  logic [7:0]  seq  [4];
  logic [7:0]  base [4];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic        wrap_done = 1'b0;

  always #5 clk = ~clk;

  assign req_data   = {8'hD0 + seq[3], 8'hC0 + seq[2], 8'hB0 + seq[1], 8'hA0 + seq[0]};
  assign req_w      = 2'b11;
  assign req_data_w = 16'h2211;
  assign full_w     = 1'b0;

  fifo_wr_arbiter #(.N_REQ(4), .DW(8), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_src     (fifo_src),
    .xfer_cnt     (xfer_cnt)
  );

  fifo_wr_arbiter #(.N_REQ(2), .DW(8), .MAX_BURST(16)) dut_w (
    .clk          (clk),
    .rst          (rst_w),
    .req          (req_w),
    .req_data     (req_data_w),
    .gnt          (gnt_w),
    .fifo_full    (full_w),
    .fifo_wr_en   (wr_en_w),
    .fifo_wr_data (wr_data_w),
    .fifo_src     (src_w),
    .xfer_cnt     (xfer_w)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs mid-cycle, then let producers advance on accepted beats.
  task automatic cyc(input string tag, input logic [3:0] g, input logic we,
                     input logic [7:0] d, input logic [1:0] s);
    logic       we_seen;
    logic [1:0] src_seen;
    @(negedge clk);
    check_val({tag, ".gnt"}, 32'(gnt), 32'(g));
    check_val({tag, ".we"}, 32'(fifo_wr_en), 32'(we));
    if (we) begin
      check_val({tag, ".data"}, 32'(fifo_wr_data), 32'(d));
      check_val({tag, ".src"}, 32'(fifo_src), 32'(s));
    end
    we_seen  = fifo_wr_en;
    src_seen = fifo_src;
    @(posedge clk);
    #1;
    if (we_seen) seq[src_seen] = seq[src_seen] + 8'd1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = 4'b0000;
    fifo_full = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) seq[i] = 8'd0;
  endtask

  initial begin
    base[0] = 8'hA0; base[1] = 8'hB0; base[2] = 8'hC0; base[3] = 8'hD0;
    for (int i = 0; i < 4; i++) seq[i] = 8'd0;
    rst = 1'b1; req = 4'b1111; fifo_full = 1'b0;

    // Reset behaviour
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst.gnt", 32'(gnt), 32'h0);
    check_val("rst.we", 32'(fifo_wr_en), 32'h0);
    check_val("rst.xfer", 32'(xfer_cnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req = 4'b0000;
    @(negedge clk);
    check_val("post.gnt", 32'(gnt), 32'h0);
    check_val("post.we", 32'(fifo_wr_en), 32'h0);
    check_val("post.src", 32'(fifo_src), 32'h0);
    check_val("post.xfer", 32'(xfer_cnt), 32'h0);
    @(posedge clk); #1;

    // Single producer: A0..A3, bubble, A4, A5
    do_reset();
    req = 4'b0001;
    cyc("t1.arb", 4'b0000, 1'b0, 8'h00, 2'd0);
    for (int b = 0; b < 4; b++) cyc("t1.beat", 4'b0001, 1'b1, 8'(8'hA0 + b), 2'd0);
    cyc("t1.bub", 4'b0000, 1'b0, 8'h00, 2'd0);
    cyc("t1.a4", 4'b0001, 1'b1, 8'hA4, 2'd0);
    cyc("t1.a5", 4'b0001, 1'b1, 8'hA5, 2'd0);
    check_val("t1.xfer", 32'(xfer_cnt), 32'd6);
    req = 4'b0000;
    cyc("t1.rel", 4'b0001, 1'b0, 8'h00, 2'd0);
    cyc("t1.idle", 4'b0000, 1'b0, 8'h00, 2'd0);

    // Round robin across all four producers
    do_reset();
    req = 4'b1111;
    cyc("t2.arb", 4'b0000, 1'b0, 8'h00, 2'd0);
    for (int t = 0; t < 5; t++) begin
      for (int b = 0; b < 4; b++)
        cyc("t2.beat", 4'(1 << (t % 4)), 1'b1, 8'(base[t % 4] + 4 * (t / 4) + b), 2'(t % 4));
      if (t < 4) cyc("t2.bub", 4'b0000, 1'b0, 8'h00, 2'd0);
    end
    check_val("t2.xfer", 32'(xfer_cnt), 32'd20);

    // Backpressure on producer 2
    do_reset();
    req = 4'b0100;
    cyc("t3.arb", 4'b0000, 1'b0, 8'h00, 2'd0);
    cyc("t3.c0", 4'b0100, 1'b1, 8'hC0, 2'd2);
    cyc("t3.c1", 4'b0100, 1'b1, 8'hC1, 2'd2);
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) cyc("t3.full", 4'b0000, 1'b0, 8'h00, 2'd0);
    check_val("t3.xfer_hold", 32'(xfer_cnt), 32'd2);
    fifo_full = 1'b0;
    cyc("t3.c2", 4'b0100, 1'b1, 8'hC2, 2'd2);
    cyc("t3.c3", 4'b0100, 1'b1, 8'hC3, 2'd2);
    check_val("t3.xfer", 32'(xfer_cnt), 32'd4);
    cyc("t3.bub", 4'b0000, 1'b0, 8'h00, 2'd0);

    // Early release by producer 1 moves the pointer past it
    do_reset();
    req = 4'b0010;
    cyc("t4.arb", 4'b0000, 1'b0, 8'h00, 2'd0);
    cyc("t4.b0", 4'b0010, 1'b1, 8'hB0, 2'd1);
    cyc("t4.b1", 4'b0010, 1'b1, 8'hB1, 2'd1);
    req = 4'b1001;
    cyc("t4.rel", 4'b0010, 1'b0, 8'h00, 2'd0);
    cyc("t4.bub", 4'b0000, 1'b0, 8'h00, 2'd0);
    cyc("t4.p3", 4'b1000, 1'b1, 8'hD0, 2'd3);
    check_val("t4.xfer", 32'(xfer_cnt), 32'd3);

    // Reset during producer 3's second beat
    do_reset();
    req = 4'b1000;
    cyc("t5.arb", 4'b0000, 1'b0, 8'h00, 2'd0);
    cyc("t5.d0", 4'b1000, 1'b1, 8'hD0, 2'd3);
    rst = 1'b1;
    cyc("t5.rst", 4'b0000, 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
    check_val("t5.xfer_clr", 32'(xfer_cnt), 32'd0);
    req = 4'b1001;
    cyc("t5.arb2", 4'b0000, 1'b0, 8'h00, 2'd0);
    cyc("t5.p0", 4'b0001, 1'b1, 8'hA0, 2'd0);
    check_val("t5.xfer", 32'(xfer_cnt), 32'd1);
    req = 4'b0000;

    while (!wrap_done) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Counter wrap on a second instance, streaming two producers with long bursts
  initial begin
    int          n;
    logic [15:0] e;
    rst_w = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_w = 1'b0;
    n = 0;
    while (xfer_w != 16'hFFFE && n < 80000) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("wrap.preload", 32'(xfer_w), 32'h0000FFFE);
    e = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      @(negedge clk);
      while (!wr_en_w && n < 40) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
      check_val("wrap.cnt", 32'(xfer_w), 32'(e));
      e = e + 16'd1;
    end
    wrap_done = 1'b1;
  end

endmodule
`default_nettype wire
